alu_seq_unit: RTL and testbench

//  Sequential, handshaked execution unit for the shared alu_pkg operation set.
//  - Takes one command (A, B, alu_op_t OP) on a valid/ready request channel.
//  - Returns RESULT/CARRY/ZERO on a valid/ready response channel.
//  - Shifts run iteratively, one bit per clock, instead of through a barrel shifter.
//  - Sits between a command producer (sequencer, bus bridge or bench driver) and a

---
 rtl/alu_seq_unit.sv | 125 ++++++++++++
 tb/tb_alu_seq_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: one command in, one response out.
// Shifts run one bit per clock through the result register instead of a barrel shifter.
module alu_seq_unit #(
  parameter int N    = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [2:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic            out_carry,
  output logic            out_zero,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  localparam int SHW = $clog2(N);
  localparam logic [SHW-1:0] CNT_ONE = 1;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [SHW-1:0]  cnt_q;
  logic [N-1:0]    res_q;
  logic            carry_q;
  logic            zero_q;
  logic [CNTW-1:0] count_q;

  logic [SHW-1:0]  shamt;
  logic [N:0]      alu_wide;
  logic            is_shift;
  logic            shift_start;
  logic [N-1:0]    shifted;

  assign shamt       = in_b[SHW-1:0];
  assign is_shift    = (in_op == ALU_SHL) || (in_op == ALU_SHR);
  assign shift_start = is_shift && (shamt != '0);
  assign shifted     = (op_q == ALU_SHR) ? (res_q >> 1) : (res_q << 1);

  // Bit N carries the add carry or the subtract borrow; shifts seed the working value with A.
  always_comb begin
    alu_wide = '0;
    case (in_op)
      ALU_ADD: alu_wide = {1'b0, in_a} + {1'b0, in_b};
      ALU_SUB: alu_wide = {1'b0, in_a} - {1'b0, in_b};
      ALU_AND: alu_wide = {1'b0, in_a & in_b};
      ALU_OR:  alu_wide = {1'b0, in_a | in_b};
      ALU_XOR: alu_wide = {1'b0, in_a ^ in_b};
      ALU_SHL: alu_wide = {1'b0, in_a};
      ALU_SHR: alu_wide = {1'b0, in_a};
      default: alu_wide = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = shift_start ? EXEC : DONE;
      EXEC: if (cnt_q == CNT_ONE) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // The last EXEC edge is the one that moves to DONE, so the zero flag is latched there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q    <= in_op;
          cnt_q   <= shamt;
          res_q   <= alu_wide[N-1:0];
          carry_q <= alu_wide[N];
          zero_q  <= !shift_start && (alu_wide[N-1:0] == '0);
        end
        EXEC: begin
          res_q <= shifted;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) zero_q <= (shifted == '0);
        end
        DONE: if (out_ready) count_q <= count_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed scenarios plus randomized
// commands compared against an arithmetic reference model.
module tb_alu_seq_unit;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        busy;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  alu_seq_unit #(.N(16), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Expected behaviour from plain arithmetic; latency counts cycles from accept to visible response.
  task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic carry, output int lat);
    int k;
    int s;
    k = int'(b[3:0]);
    carry = 1'b0;
    lat = 1;
    res = '0;
    case (op)
      OP_ADD: begin s = int'(a) + int'(b); res = s[15:0]; carry = (s >= 65536); end
      OP_SUB: begin res = a - b; carry = (a < b); end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin res = a << k; lat = (k == 0) ? 1 : k + 1; end
      OP_SHR: begin res = a >> k; lat = (k == 0) ? 1 : k + 1; end
      default: res = '0;
    endcase
  endtask

  // Drives one command from IDLE, waits for the response, optionally stalls, then completes it.
  task automatic do_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input int stall, output logic [15:0] r, output logic c,
                        output logic z, output int lat);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_result; c = out_carry; z = out_zero;
    if (!out_valid) begin
      $display("[TB] FAIL response_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
      n_err++;
      n_vec++;
    end
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    if (in_ready !== 1'b1) begin $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); n_err++; end
    n_vec++;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); n_err++; end
    n_vec++;
    if ({out_result, out_carry, out_zero} !== 18'h0) begin
      $display("[TB] FAIL reset_outputs: result=%h carry=%b zero=%b want 0/0/0", out_result, out_carry, out_zero);
      n_err++;
    end
    n_vec++;
    if (busy !== 1'b0 || op_count !== 16'd0) begin
      $display("[TB] FAIL reset_busy_count: busy=%b count=%0d want 0/0", busy, op_count); n_err++;
    end
    n_vec++;
    exp_count = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [15:0] r; logic c, z; int lat;
    do_cmd(16'hFFFF, 16'h0001, OP_ADD, 0, r, c, z, lat);
    if ({r, c, z} !== {16'h0000, 1'b1, 1'b1} || lat != 1) begin
      $display("[TB] FAIL add_wrap: result=%h carry=%b zero=%b lat=%0d want 0000/1/1 lat 1", r, c, z, lat);
      n_err++;
    end
    n_vec++;
    if (op_count !== 16'(exp_count)) begin
      $display("[TB] FAIL add_count: got %0d want %0d", op_count, exp_count); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_sub;
    logic [15:0] r; logic c, z; int lat;
    do_cmd(16'h0003, 16'h0005, OP_SUB, 0, r, c, z, lat);
    if ({r, c, z} !== {16'hFFFE, 1'b1, 1'b0}) begin
      $display("[TB] FAIL sub_borrow: result=%h carry=%b zero=%b want FFFE/1/0", r, c, z); n_err++;
    end
    n_vec++;
    do_cmd(16'h1234, 16'h1234, OP_SUB, 0, r, c, z, lat);
    if ({r, c, z} !== {16'h0000, 1'b0, 1'b1}) begin
      $display("[TB] FAIL sub_equal: result=%h carry=%b zero=%b want 0000/0/1", r, c, z); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_shift;
    logic [15:0] r; logic c, z; int lat;
    do_cmd(16'h0001, 16'h000F, OP_SHL, 0, r, c, z, lat);
    if (r !== 16'h8000 || lat != 16) begin
      $display("[TB] FAIL shl_max: result=%h lat=%0d want 8000 lat 16", r, lat); n_err++;
    end
    n_vec++;
    do_cmd(16'h8000, 16'h0013, OP_SHR, 0, r, c, z, lat);
    if (r !== 16'h1000 || c !== 1'b0 || lat != 4) begin
      $display("[TB] FAIL shr_k3: result=%h carry=%b lat=%0d want 1000/0 lat 4", r, c, lat); n_err++;
    end
    n_vec++;
    do_cmd(16'hBEEF, 16'h0010, OP_SHL, 0, r, c, z, lat);
    if (r !== 16'hBEEF || lat != 1) begin
      $display("[TB] FAIL shl_k0: result=%h lat=%0d want BEEF lat 1", r, lat); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_backpressure;
    logic [15:0] count_before;
    int bad;
    count_before = op_count;
    out_ready = 1'b0;
    in_a = 16'hAAAA; in_b = 16'h5555; in_op = OP_XOR; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h0001; in_b = 16'h0001; in_op = OP_ADD;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_result !== 16'hFFFF || out_carry !== 1'b0 || out_zero !== 1'b0 ||
          in_ready !== 1'b0 || op_count !== count_before) bad++;
      @(posedge clk); #1;
    end
    if (bad != 0) begin
      $display("[TB] FAIL stall_hold: %0d unstable cycles, result=%h in_ready=%b count=%0d want 0", bad,
               out_result, in_ready, op_count);
      n_err++;
    end
    n_vec++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    if (op_count !== 16'(exp_count) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("[TB] FAIL stall_release: count=%0d out_valid=%b in_ready=%b want %0d/0/1", op_count,
               out_valid, in_ready, exp_count);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] r; logic c, z; int lat; int seen;
    in_a = 16'h0001; in_b = 16'h000A; in_op = OP_SHL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (busy !== 1'b1) begin $display("[TB] FAIL exec_busy: got %b want 1", busy); n_err++; end
    n_vec++;
    #2 rst_n = 1'b0;
    #1;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0 ||
        out_carry !== 1'b0 || out_zero !== 1'b0 || op_count !== 16'h0) begin
      $display("[TB] FAIL async_reset: busy=%b in_ready=%b out_valid=%b result=%h count=%0d want 0/1/0/0000/0",
               busy, in_ready, out_valid, out_result, op_count);
      n_err++;
    end
    n_vec++;
    exp_count = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    if (seen != 0) begin $display("[TB] FAIL reset_no_response: out_valid seen %0d cycles want 0", seen); n_err++; end
    n_vec++;
    do_cmd(16'h0002, 16'h0003, OP_ADD, 0, r, c, z, lat);
    if (r !== 16'h0005 || c !== 1'b0 || z !== 1'b0) begin
      $display("[TB] FAIL post_reset_add: result=%h carry=%b zero=%b want 0005/0/0", r, c, z); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_undefined;
    logic [15:0] r; logic c, z; int lat;
    do_cmd(16'($urandom), 16'($urandom), OP_BAD, 0, r, c, z, lat);
    if ({r, c, z} !== {16'h0000, 1'b0, 1'b1} || lat != 1) begin
      $display("[TB] FAIL undefined_op: result=%h carry=%b zero=%b lat=%0d want 0000/0/1 lat 1", r, c, z, lat);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_random;
    logic [15:0] a, b, r, er; logic [2:0] op; logic c, z, ec; int lat, elat;
    test_reset;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      op = 3'($urandom_range(0, 7));
      if (i % 4 == 0) a = b;
      ref_model(op, a, b, er, ec, elat);
      do_cmd(a, b, op, int'($urandom_range(0, 2)), r, c, z, lat);
      if (r !== er || c !== ec || z !== (er == 16'h0) || lat != elat) begin
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: result=%h carry=%b zero=%b lat=%0d want %h/%b/%b lat %0d",
                 i, op, a, b, r, c, z, lat, er, ec, (er == 16'h0), elat);
        n_err++;
      end
      n_vec++;
    end
    if (op_count !== 16'd40) begin
      $display("[TB] FAIL random_count: got %0d want 40", op_count); n_err++;
    end
    n_vec++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_shift;
    test_backpressure;
    test_reset_mid;
    test_undefined;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
